// File: rtl/booth_controller.sv
// booth_controller
// Sequencing FSM for a radix-2 Booth multiplier. It drives the load and
// update enables of the 33-bit partial-product register {A, Q, Q-1}. It
// also drives the add/subtract select of the shared adder, counts the
// WIDTH_IN Booth iterations, and runs the start/done/ack handshake with
// the requester.
//
// Ports
//   clk       clock, rising edge
//   reset     asynchronous, active-high
//   start_i   multiply request (taken in IDLE, or in DONE together with ack_i)
//   ack_i     requester has taken the result (DONE only)
//   q_bits_i  {Q0, Q-1} from the partial-product register
//   en_i      load register with {16'h0000, B, 1'b0}
//   en_pp     capture adder + arithmetic-shift result
//   en_fp     latch final product
//   add_o     adder performs A + M
//   sub_o     adder performs A - M
//   busy_o    high in LOAD, EVAL, FINAL
//   done_o    product valid (DONE)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start_i, all outputs low
// LOAD  | one cycle: load multiplier into Q, clear A and Q-1, counter <= 0
// EVAL  | one Booth iteration per cycle, WIDTH_IN cycles in total
// FINAL | one cycle: latch {A, Q} as the product
// DONE  | product valid, held until ack_i

module booth_controller #(
   parameter int WIDTH_IN = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic       ack_i,
   input  logic [1:0] q_bits_i,
   output logic       en_i,
   output logic       en_pp,
   output logic       en_fp,
   output logic       add_o,
   output logic       sub_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EVAL  = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_IN - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      en_i      = 1'b0;
      en_pp     = 1'b0;
      en_fp     = 1'b0;
      add_o     = 1'b0;
      sub_o     = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) state_nxt = LOAD;
         end
         LOAD: begin
            en_i      = 1'b1;
            busy_o    = 1'b1;
            cnt_nxt   = '0;
            state_nxt = EVAL;
         end
         EVAL: begin
            en_pp  = 1'b1;
            busy_o = 1'b1;
            // Booth recoding of {Q0, Q-1}: 01 adds M, 10 subtracts M,
            // 00/11 only shift.
            add_o  = (q_bits_i == 2'b01);
            sub_o  = (q_bits_i == 2'b10);
            // The counter holds at the last value instead of stepping past
            // WIDTH_IN-1; LOAD is the only place it is cleared.
            if (cnt == CNT_LAST) begin
               state_nxt = FINAL;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         FINAL: begin
            en_fp     = 1'b1;
            busy_o    = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            done_o = 1'b1;
            if (ack_i) state_nxt = start_i ? LOAD : IDLE;
         end
         // Unused encodings fall back to IDLE with every output low.
         default: state_nxt = IDLE;
      endcase
   end

endmodule
